pfu_fetch_ctrl: RTL and testbench

Prefetch fetch controller: the write-side companion of the instruction prefetch FIFO. It generates sequential word-aligned instruction-bus read requests and pushes each response, tagged with its PC and bus-error flag, into the FIFO. It tracks FIFO occupancy itself through credits, so the FIFO never overflows. On a jump it flushes the FIFO, discards responses already in flight and restarts fetching at the new address. It sits between the instruction bus and the prefetch FIFO that feeds decode.

---
 rtl/pfu_pkg.sv | 36 +++
 rtl/pfu_fetch_ctrl_if.sv | 50 +++++
 rtl/pfu_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_pfu_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfu_pkg.sv
// pfu_pkg: shared types and constants for the prefetch fetch controller.
// Defines the controller state encoding and the layout of one prefetch FIFO
// entry {err, pc[31:0], instr[31:0]}.
package pfu_pkg;

  // Controller state: FETCH issues requests, HALT parks after a bus error.
  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } pfu_state_e;

  // Prefetch FIFO entry layout.
  localparam int PFU_ENTRY_W     = 65;
  localparam int PFU_ERR_BIT     = 64;
  localparam int PFU_PC_MSB      = 63;
  localparam int PFU_PC_LSB      = 32;
  localparam int PFU_INSTR_MSB   = 31;
  localparam int PFU_INSTR_LSB   = 0;

  typedef logic [PFU_ENTRY_W-1:0] pfu_entry_t;

  // Assemble one FIFO entry from its fields.
  function automatic pfu_entry_t pfu_pack_entry(
    input logic        err,
    input logic [31:0] pc,
    input logic [31:0] instr
  );
    pfu_entry_t e;
    e = '0;
    e[PFU_ERR_BIT]                  = err;
    e[PFU_PC_MSB:PFU_PC_LSB]        = pc;
    e[PFU_INSTR_MSB:PFU_INSTR_LSB]  = instr;
    return e;
  endfunction

endpackage

// File: rtl/pfu_fetch_ctrl_if.sv
// pfu_fetch_ctrl_if: instruction-bus request/response channel plus the
// write side of the prefetch FIFO, as seen by the fetch controller.
// The master modport is the controller; the slave modport is the bus and
// FIFO environment around it.
interface pfu_fetch_ctrl_if;
  import pfu_pkg::*;

  // Instruction bus request channel
  logic        ireqvalid_o;
  logic        ireqready_i;
  logic [31:0] ireqaddr_o;

  // Instruction bus response channel (in order, no back-pressure)
  logic        irspvalid_i;
  logic        irsprerr_i;
  logic [31:0] irspdata_i;

  // Prefetch FIFO write side and consumer read strobe
  logic        fifo_flush_o;
  logic        fifo_wr_o;
  pfu_entry_t  fifo_din_o;
  logic        fifo_rd_i;

  modport master (
    output ireqvalid_o,
    input  ireqready_i,
    output ireqaddr_o,
    input  irspvalid_i,
    input  irsprerr_i,
    input  irspdata_i,
    output fifo_flush_o,
    output fifo_wr_o,
    output fifo_din_o,
    input  fifo_rd_i
  );

  modport slave (
    input  ireqvalid_o,
    output ireqready_i,
    input  ireqaddr_o,
    output irspvalid_i,
    output irsprerr_i,
    output irspdata_i,
    input  fifo_flush_o,
    input  fifo_wr_o,
    input  fifo_din_o,
    output fifo_rd_i
  );

endinterface

// File: rtl/pfu_fetch_ctrl.sv
// pfu_fetch_ctrl: prefetch fetch controller (write side of the prefetch FIFO).
// Issues sequential word-aligned instruction reads, pushes each kept response
// into the FIFO tagged with its PC and error flag, and tracks FIFO occupancy
// plus outstanding requests as credits so the FIFO cannot overflow. A jump
// flushes the FIFO, marks all in-flight responses for discard and restarts
// fetching at the (word-aligned) target.
// Optional build macro: PFU_DISCARD_CNT_EN adds discard_cnt_o, a wrapping
// count of every response that was not written to the FIFO.
module pfu_fetch_ctrl
  import pfu_pkg::*;
#(
  parameter int          C_FIFO_DEPTH_X = 2,
  parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             resetb_i,
  input  logic             clk_en_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_addr_i,
  pfu_fetch_ctrl_if.master bus
`ifdef PFU_DISCARD_CNT_EN
  ,
  output logic [31:0]      discard_cnt_o
`endif
);

  // Counter width: occupancy, outstanding and discard counts all reach D.
  localparam int          CW       = C_FIFO_DEPTH_X + 1;
  localparam logic [CW:0] ONE_EXT  = 1;
  localparam logic [CW:0] DEPTH    = ONE_EXT << C_FIFO_DEPTH_X;
  localparam logic [31:0] RESET_PC = {C_RESET_VECTOR[31:2], 2'b00};

  pfu_state_e    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;

  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          jump_fire;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_keep;
  logic          rsp_disc;
  logic          rd_fire;
  logic [31:0]   jump_target;

  // The two address LSBs of a jump target carry no information.
  logic          unused_jump_lsbs;
  assign unused_jump_lsbs = ^jump_addr_i[1:0];

  // Decode this cycle's events; nothing is acted upon while the clock enable is low.
  always_comb begin
    credit_used = {1'b0, occ_q} + {1'b0, out_q};
    credit_ok   = (credit_used < DEPTH);
    jump_fire   = clk_en_i & jump_i;
    jump_target = {jump_addr_i[31:2], 2'b00};
    req_valid   = clk_en_i & (state_q == FETCH) & credit_ok & ~jump_i;
    req_fire    = req_valid & bus.ireqready_i;
    rsp_keep    = clk_en_i & bus.irspvalid_i & (disc_q == '0) & ~jump_i;
    rsp_disc    = clk_en_i & bus.irspvalid_i & (disc_q != '0);
    rd_fire     = clk_en_i & bus.fifo_rd_i;
  end

  // Bus request and FIFO write outputs; the response path to the FIFO is combinational.
  assign bus.ireqvalid_o  = req_valid;
  assign bus.ireqaddr_o   = pc_q;
  assign bus.fifo_flush_o = jump_fire;
  assign bus.fifo_wr_o    = rsp_keep;
  assign bus.fifo_din_o   = pfu_pack_entry(bus.irsprerr_i, rpc_q, bus.irspdata_i);

  // Next-state: a jump overrides everything; otherwise all credit moves in the cycle are summed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    occ_d   = occ_q;
    out_d   = out_q;
    disc_d  = disc_q;
    if (jump_fire) begin
      state_d = FETCH;
      pc_d    = jump_target;
      rpc_d   = jump_target;
      occ_d   = '0;
      out_d   = '0;
      // Every request still in flight becomes stale; a response landing in
      // the jump cycle itself is consumed (dropped) right now.
      disc_d  = disc_q + out_q - CW'(bus.irspvalid_i);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_keep) begin
        rpc_d = rpc_q + 32'd4;
        if (bus.irsprerr_i) begin
          state_d = HALT;
        end
      end
      out_d  = out_q + CW'(req_fire) - CW'(rsp_keep);
      occ_d  = occ_q + CW'(rsp_keep) - CW'(rd_fire);
      disc_d = disc_q - CW'(rsp_disc);
    end
  end

  // Controller state registers with asynchronous active-low reset; held while disabled.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      occ_q   <= '0;
      out_q   <= '0;
      disc_q  <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      occ_q   <= occ_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

`ifdef PFU_DISCARD_CNT_EN
  logic        rsp_gone;
  logic [31:0] dcnt_q, dcnt_d;

  // Any response that is not written (stale, or arriving with a jump) counts as discarded.
  always_comb begin
    rsp_gone = clk_en_i & bus.irspvalid_i & ~rsp_keep;
    dcnt_d   = dcnt_q + {31'd0, rsp_gone};
  end

  // Discard counter register, wraps at 2^32.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      dcnt_q <= '0;
    end else if (clk_en_i) begin
      dcnt_q <= dcnt_d;
    end
  end

  assign discard_cnt_o = dcnt_q;
`endif

endmodule

// File: tb/tb_pfu_fetch_ctrl.sv
// tb_pfu_fetch_ctrl: self-checking bench for pfu_fetch_ctrl (D=4).
// A bus model returns responses in order after a programmable latency; each
// response that should be kept pushes its expected FIFO entry onto a
// scoreboard queue, which is popped and compared when the DUT writes.
// A second instance with reset vector 0xFFFF_FFFA checks address wrap.
module tb_pfu_fetch_ctrl;
  import pfu_pkg::*;

  localparam int DEPTH_X = 2;
  localparam int DEPTH   = 1 << DEPTH_X;

  typedef struct {
    logic [31:0] addr;
    int          gen;
    int          due;
  } bus_item_t;

  logic        clk = 1'b0;
  logic        resetb;
  logic        clk_en;
  logic        jump;
  logic [31:0] jump_addr;
  logic        ready;

  pfu_fetch_ctrl_if bus_if();
  pfu_fetch_ctrl_if wrap_if();

`ifdef PFU_DISCARD_CNT_EN
  logic [31:0] discard_cnt;
  logic [31:0] wrap_dcnt_unused;
`endif

  always #5 clk = ~clk;

  pfu_fetch_ctrl #(
    .C_FIFO_DEPTH_X (DEPTH_X),
    .C_RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk_i        (clk),
    .resetb_i     (resetb),
    .clk_en_i     (clk_en),
    .jump_i       (jump),
    .jump_addr_i  (jump_addr),
    .bus          (bus_if)
`ifdef PFU_DISCARD_CNT_EN
    ,
    .discard_cnt_o(discard_cnt)
`endif
  );

  pfu_fetch_ctrl #(
    .C_FIFO_DEPTH_X (DEPTH_X),
    .C_RESET_VECTOR (32'hFFFF_FFFA)
  ) dut_wrap (
    .clk_i        (clk),
    .resetb_i     (resetb),
    .clk_en_i     (clk_en),
    .jump_i       (1'b0),
    .jump_addr_i  (32'h0),
    .bus          (wrap_if)
`ifdef PFU_DISCARD_CNT_EN
    ,
    .discard_cnt_o(wrap_dcnt_unused)
`endif
  );

  assign wrap_if.ireqready_i = 1'b1;
  assign wrap_if.irspvalid_i = 1'b0;
  assign wrap_if.irsprerr_i  = 1'b0;
  assign wrap_if.irspdata_i  = 32'h0;
  assign wrap_if.fifo_rd_i   = 1'b0;

  // Scoreboard and model state
  bus_item_t   bus_q[$];
  pfu_entry_t  exp_q[$];
  int          cyc, gen, lat;
  int          fifo_cnt, cur_out;
  int          stale_cnt, dut_sum, dut_nreq, wrap_n;
  logic        halt, err_en;
  logic [31:0] exp_pc, err_addr;
  logic [31:0] wrap_exp [3];
  int          n_checks, n_pass;
`ifdef PFU_DISCARD_CNT_EN
  logic [31:0] dcnt0;
`endif

  task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    bus_q.delete();
    exp_q.delete();
    fifo_cnt = 0;
    cur_out  = 0;
    dut_sum  = 0;
    exp_pc   = 32'h0;
    halt     = 1'b0;
  endtask

  // One clock cycle: drive inputs at posedge+1, check at posedge+2, update model.
  task automatic step(input logic j, input logic [31:0] ja, input logic rd);
    logic        rsp, kept, err, exp_valid, rdv, acc;
    logic [31:0] data;
    bus_item_t   it;
    pfu_entry_t  exp_e;
    rsp  = 1'b0;
    kept = 1'b0;
    err  = 1'b0;
    data = $urandom;
    it   = '{addr: 32'h0, gen: 0, due: 0};
    if (clk_en && bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      rsp  = 1'b1;
      it   = bus_q.pop_front();
      err  = err_en && (it.addr == err_addr);
      kept = (it.gen == gen) && !j;
    end
    rdv = clk_en && rd && !j && (fifo_cnt > 0);
    bus_if.irspvalid_i = rsp;
    bus_if.irsprerr_i  = err;
    bus_if.irspdata_i  = data;
    bus_if.fifo_rd_i   = rdv;
    bus_if.ireqready_i = ready;
    jump      = j;
    jump_addr = ja;
    if (kept) exp_q.push_back(pfu_pack_entry(err, it.addr, data));
    exp_valid = clk_en && !halt && (fifo_cnt + cur_out < DEPTH) && !j;
    #1;
    check_val("ireqvalid", 65'(bus_if.ireqvalid_o), 65'(exp_valid));
    if (exp_valid) check_val("ireqaddr", 65'(bus_if.ireqaddr_o), 65'(exp_pc));
    check_val("fifo_flush", 65'(bus_if.fifo_flush_o), 65'(clk_en && j));
    check_val("fifo_wr", 65'(bus_if.fifo_wr_o), 65'(kept));
    if (kept) begin
      exp_e = exp_q.pop_front();
      check_val("fifo_din", bus_if.fifo_din_o, exp_e);
    end
    if (rsp && !kept) stale_cnt++;
    if (wrap_if.ireqvalid_o && wrap_n < 3) begin
      check_val("wrap_addr", 65'(wrap_if.ireqaddr_o), 65'(wrap_exp[wrap_n]));
      wrap_n++;
    end
    acc = bus_if.ireqvalid_o && ready;
    if (clk_en) begin
      if (acc) dut_nreq++;
      if (j) dut_sum = 0;
      else dut_sum = dut_sum + int'(acc) - int'(rdv);
      if (j) begin
        gen++;
        fifo_cnt = 0;
        cur_out  = 0;
        exp_pc   = {ja[31:2], 2'b00};
        halt     = 1'b0;
      end else begin
        if (exp_valid && ready) begin
          bus_q.push_back('{addr: exp_pc, gen: gen, due: cyc + lat});
          exp_pc  = exp_pc + 32'd4;
          cur_out++;
        end
        if (kept) begin
          fifo_cnt++;
          cur_out--;
          if (err) halt = 1'b1;
        end
        if (rdv) fifo_cnt--;
      end
    end
    check_val("credit_bound", 65'(dut_sum <= DEPTH), 65'(1));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic rd);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rd);
  endtask

  initial begin
    resetb    = 1'b0;
    clk_en    = 1'b1;
    jump      = 1'b0;
    jump_addr = 32'h0;
    ready     = 1'b1;
    bus_if.ireqready_i = 1'b1;
    bus_if.irspvalid_i = 1'b0;
    bus_if.irsprerr_i  = 1'b0;
    bus_if.irspdata_i  = 32'h0;
    bus_if.fifo_rd_i   = 1'b0;
    cyc = 0; gen = 0; lat = 1;
    stale_cnt = 0; dut_nreq = 0; wrap_n = 0;
    err_en = 1'b0; err_addr = 32'h0;
    n_checks = 0; n_pass = 0;
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;

    // Fill: exactly four requests 0x0..0xC, then stall on credits
    lat = 1;
    run(10, 1'b0);
    check_val("fill_reqs", 65'(dut_nreq), 65'(4));

    // One FIFO read frees one credit -> one request at 0x10
    step(1'b0, 32'h0, 1'b1);
    run(5, 1'b0);
    check_val("refill_reqs", 65'(dut_nreq), 65'(5));

    // Drain, then jump to 0x1003 with three requests outstanding
    ready = 1'b0;
    run(8, 1'b1);
    lat   = 4;
    ready = 1'b1;
    run(3, 1'b0);
`ifdef PFU_DISCARD_CNT_EN
    dcnt0 = discard_cnt;
`endif
    step(1'b1, 32'h0000_1003, 1'b0);
    run(12, 1'b1);
`ifdef PFU_DISCARD_CNT_EN
    check_val("discard_jump", 65'(discard_cnt - dcnt0), 65'(3));
`endif

    // Bus error at pc 0x8 halts fetching until a jump to 0x40
    lat      = 1;
    err_en   = 1'b1;
    err_addr = 32'h8;
    step(1'b1, 32'h0, 1'b0);
    run(20, 1'b1);
    check_val("halt_valid", 65'(bus_if.ireqvalid_o), 65'(0));
    err_en = 1'b0;
    step(1'b1, 32'h0000_0040, 1'b0);
    run(8, 1'b1);

    // Back-to-back jumps with 2 then 1 outstanding
    ready = 1'b0;
    run(10, 1'b1);
    lat   = 6;
    ready = 1'b1;
`ifdef PFU_DISCARD_CNT_EN
    dcnt0 = discard_cnt;
`endif
    run(2, 1'b0);
    step(1'b1, 32'h0000_0200, 1'b0);
    run(1, 1'b0);
    step(1'b1, 32'h0000_0300, 1'b0);
    run(20, 1'b1);
`ifdef PFU_DISCARD_CNT_EN
    check_val("discard_b2b", 65'(discard_cnt - dcnt0), 65'(3));
    check_val("discard_total", 65'(discard_cnt), 65'(stale_cnt));
`endif

    // Clock enable low: everything holds
    clk_en = 1'b0;
    run(3, 1'b1);
    clk_en = 1'b1;
    run(10, 1'b1);

    // Asynchronous reset in mid-operation
    bus_if.irspvalid_i = 1'b0;
    bus_if.fifo_rd_i   = 1'b0;
    jump   = 1'b0;
    resetb = 1'b0;
    #1;
    check_val("rst_addr", 65'(bus_if.ireqaddr_o), 65'(0));
    check_val("rst_valid", 65'(bus_if.ireqvalid_o), 65'(1));
    check_val("rst_wr", 65'(bus_if.fifo_wr_o), 65'(0));
    @(posedge clk);
    #1 resetb = 1'b1;
    model_reset();
    lat = 1;
    run(8, 1'b1);

    check_val("wrap_cnt", 65'(wrap_n), 65'(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
